// File: rtl/ds1302_responder.sv
// DS1302-style serial RTC responder: synchronizes the 3-wire bus, decodes
// command/data frames, and keeps a BCD seconds/minutes/hours clock.
module ds1302_responder #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rtc_ce,
    input  logic       rtc_sclk,
    input  logic       rtc_io_in,
    output logic       rtc_io_out,
    output logic       rtc_io_oe,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hour,
    output logic       reg_wr,
    output logic [2:0] reg_wr_addr
);

    localparam int CW = (TICK_DIV > 4) ? $clog2(TICK_DIV) : 2;

    typedef enum logic [2:0] {
        S_DISARMED,
        S_IDLE,
        S_CMD,
        S_WDATA,
        S_RDATA,
        S_SKIP
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [1:0]  r_ce_sync;
    logic [1:0]  r_sclk_sync;
    logic [1:0]  r_io_sync;
    logic        r_sclk_d;
    logic [1:0]  r_sync_vld;

    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic [2:0]  r_addr;
    logic [7:0]  r_rd_buf;
    logic [3:0]  r_rd_idx;
    logic        r_io_out;
    logic        r_io_oe;
    logic        r_reg_wr;
    logic [2:0]  r_reg_wr_addr;

    logic [7:0]  r_regs [0:7];
    logic [CW-1:0] r_tick_cnt;

    logic        w_ce;
    logic        w_rise;
    logic        w_fall;
    logic [7:0]  w_shift_byte;
    logic        w_cmd_ok;
    logic        w_shift;
    logic        w_cmd_done;
    logic        w_commit_raw;
    logic        w_commit;
    logic        w_drive;
    logic        w_oe_clr;

    logic        w_ch;
    logic        w_tick;
    logic        w_sec_wrap;
    logic        w_min_wrap;
    logic        w_hour_wrap;
    logic        w_min_carry;
    logic        w_hour_carry;
    logic [7:0]  w_sec_next;
    logic [7:0]  w_min_next;
    logic [7:0]  w_hour_next;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'h9)
            return {v[7:4] + 4'h1, 4'h0};
        else
            return v + 8'h01;
    endfunction

    // Two-flop synchronizers; r_sync_vld marks when the second stage holds real pin data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_sync   <= 2'b00;
            r_sclk_sync <= 2'b00;
            r_io_sync   <= 2'b00;
            r_sclk_d    <= 1'b0;
            r_sync_vld  <= 2'b00;
        end else begin
            r_ce_sync   <= {r_ce_sync[0], rtc_ce};
            r_sclk_sync <= {r_sclk_sync[0], rtc_sclk};
            r_io_sync   <= {r_io_sync[0], rtc_io_in};
            r_sclk_d    <= r_sclk_sync[1];
            r_sync_vld  <= {r_sync_vld[0], 1'b1};
        end
    end

    assign w_ce         = r_ce_sync[1];
    assign w_rise       = r_sclk_sync[1] & ~r_sclk_d;
    assign w_fall       = ~r_sclk_sync[1] & r_sclk_d;
    assign w_shift_byte = {r_io_sync[1], r_shift[7:1]};
    assign w_cmd_ok     = w_shift_byte[7] & ~w_shift_byte[6] & (w_shift_byte[5:4] == 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_DISARMED;
        else
            r_state <= w_state_next;
    end

    // S_DISARMED waits for a clean CE low so a frame cut by reset is never resumed.
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_cmd_done   = 1'b0;
        w_commit_raw = 1'b0;
        w_drive      = 1'b0;
        w_oe_clr     = 1'b0;
        case (r_state)
            S_DISARMED: begin
                if (r_sync_vld[1] && !w_ce)
                    w_state_next = S_IDLE;
            end
            S_IDLE: begin
                w_oe_clr = 1'b1;
                if (w_ce)
                    w_state_next = S_CMD;
            end
            S_CMD: begin
                if (!w_ce) begin
                    w_state_next = S_IDLE;
                    w_oe_clr     = 1'b1;
                end else if (w_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 4'd7) begin
                        w_cmd_done = 1'b1;
                        if (!w_cmd_ok)
                            w_state_next = S_SKIP;
                        else if (w_shift_byte[0])
                            w_state_next = S_RDATA;
                        else
                            w_state_next = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                if (!w_ce) begin
                    w_state_next = S_IDLE;
                    w_oe_clr     = 1'b1;
                end else if (w_rise) begin
                    w_shift = 1'b1;
                    if (r_bit_cnt == 4'd15) begin
                        w_commit_raw = 1'b1;
                        w_state_next = S_SKIP;
                    end
                end
            end
            S_RDATA: begin
                if (!w_ce) begin
                    w_state_next = S_IDLE;
                    w_oe_clr     = 1'b1;
                end else if (w_fall) begin
                    if (r_rd_idx < 4'd8) begin
                        w_drive = 1'b1;
                    end else begin
                        w_oe_clr     = 1'b1;
                        w_state_next = S_SKIP;
                    end
                end
            end
            S_SKIP: begin
                if (!w_ce) begin
                    w_state_next = S_IDLE;
                    w_oe_clr     = 1'b1;
                end
            end
            default: w_state_next = S_DISARMED;
        endcase
    end

    // Write protect covers addresses 0-6; control is always writable so WP can be cleared.
    assign w_commit = w_commit_raw && ((r_addr == 3'd7) || !r_regs[7][7]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt     <= 4'd0;
            r_shift       <= 8'h00;
            r_addr        <= 3'd0;
            r_rd_buf      <= 8'h00;
            r_rd_idx      <= 4'd0;
            r_io_out      <= 1'b0;
            r_io_oe       <= 1'b0;
            r_reg_wr      <= 1'b0;
            r_reg_wr_addr <= 3'd0;
        end else begin
            if (r_state == S_IDLE || r_state == S_DISARMED)
                r_bit_cnt <= 4'd0;
            else if (w_shift)
                r_bit_cnt <= r_bit_cnt + 4'd1;

            if (w_shift)
                r_shift <= w_shift_byte;

            if (w_cmd_done) begin
                r_addr   <= w_shift_byte[3:1];
                r_rd_buf <= r_regs[w_shift_byte[3:1]];
                r_rd_idx <= 4'd0;
            end else if (w_drive) begin
                r_rd_buf <= {1'b0, r_rd_buf[7:1]};
                r_rd_idx <= r_rd_idx + 4'd1;
            end

            if (w_drive) begin
                r_io_out <= r_rd_buf[0];
                r_io_oe  <= 1'b1;
            end else if (w_oe_clr) begin
                r_io_out <= 1'b0;
                r_io_oe  <= 1'b0;
            end

            r_reg_wr <= w_commit;
            if (w_commit)
                r_reg_wr_addr <= r_addr;
        end
    end

    assign w_ch         = r_regs[0][7];
    assign w_tick       = !w_ch && (r_tick_cnt == CW'(TICK_DIV - 1));
    assign w_sec_wrap   = (r_regs[0][6:0] == 7'h59);
    assign w_min_wrap   = (r_regs[1][6:0] == 7'h59);
    assign w_hour_wrap  = (r_regs[2][5:0] == 6'h23);
    assign w_min_carry  = w_tick && w_sec_wrap;
    assign w_hour_carry = w_min_carry && w_min_wrap;
    assign w_sec_next   = w_sec_wrap  ? {r_regs[0][7], 7'h00}   : bcd_inc(r_regs[0]);
    assign w_min_next   = w_min_wrap  ? {r_regs[1][7], 7'h00}   : bcd_inc(r_regs[1]);
    assign w_hour_next  = w_hour_wrap ? {r_regs[2][7:6], 6'h00} : bcd_inc(r_regs[2]);

    // A serial commit wins over the tick for its own register; carries still ripple onward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regs[0] <= 8'h80;
            for (int i = 1; i < 7; i++)
                r_regs[i] <= 8'h00;
            r_regs[7]  <= 8'h80;
            r_tick_cnt <= '0;
        end else begin
            if (w_commit && r_addr == 3'd0)
                r_regs[0] <= w_shift_byte;
            else if (w_tick)
                r_regs[0] <= w_sec_next;

            if (w_commit && r_addr == 3'd1)
                r_regs[1] <= w_shift_byte;
            else if (w_min_carry)
                r_regs[1] <= w_min_next;

            if (w_commit && r_addr == 3'd2)
                r_regs[2] <= w_shift_byte;
            else if (w_hour_carry)
                r_regs[2] <= w_hour_next;

            for (int i = 3; i < 8; i++)
                if (w_commit && r_addr == 3'(i))
                    r_regs[i] <= w_shift_byte;

            if (w_commit && r_addr == 3'd0)
                r_tick_cnt <= '0;
            else if (w_tick)
                r_tick_cnt <= '0;
            else if (!w_ch)
                r_tick_cnt <= r_tick_cnt + CW'(1);
        end
    end

    assign rtc_io_out  = r_io_out;
    assign rtc_io_oe   = r_io_oe;
    assign time_sec    = r_regs[0];
    assign time_min    = r_regs[1];
    assign time_hour   = r_regs[2];
    assign reg_wr      = r_reg_wr;
    assign reg_wr_addr = r_reg_wr_addr;

endmodule

// File: tb/tb_ds1302_responder.sv
// Directed bench for ds1302_responder: table of write frames plus hand sequences
// for ticking, rollover, reads, aborted frames and reset mid-read.
module tb_ds1302_responder;

    localparam int TICK_DIV = 200;
    localparam int H        = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rtc_ce = 1'b0;
    logic       rtc_sclk = 1'b0;
    logic       rtc_io_in = 1'b0;
    logic       rtc_io_out;
    logic       rtc_io_oe;
    logic [7:0] time_sec;
    logic [7:0] time_min;
    logic [7:0] time_hour;
    logic       reg_wr;
    logic [2:0] reg_wr_addr;

    ds1302_responder #(.TICK_DIV(TICK_DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rtc_ce     (rtc_ce),
        .rtc_sclk   (rtc_sclk),
        .rtc_io_in  (rtc_io_in),
        .rtc_io_out (rtc_io_out),
        .rtc_io_oe  (rtc_io_oe),
        .time_sec   (time_sec),
        .time_min   (time_min),
        .time_hour  (time_hour),
        .reg_wr     (reg_wr),
        .reg_wr_addr(reg_wr_addr)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         wr_cnt = 0;
    int         wr_cyc = 0;
    logic [2:0] wr_addr_last = 3'd0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            wr_cnt       <= wr_cnt + 1;
            wr_cyc       <= cyc;
            wr_addr_last <= reg_wr_addr;
        end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        int         exp_wr;
        logic [2:0] exp_addr;
        int         sel;      // 0 sec, 1 min, 2 hour, 3 nothing to check
        logic [7:0] exp_val;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rtc_io_in = b;
        repeat (H) @(negedge clk);
        rtc_sclk = 1'b1;
        repeat (H) @(negedge clk);
        rtc_sclk = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic frame_start();
        rtc_ce = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic frame_end();
        rtc_ce    = 1'b0;
        rtc_io_in = 1'b0;
        repeat (2 * H) @(negedge clk);
    endtask

    task automatic wr_xfer(input logic [7:0] cmd, input logic [7:0] data);
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(cmd[i]);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        frame_end();
    endtask

    task automatic sclk_pulse();
        rtc_sclk = 1'b1;
        repeat (H) @(negedge clk);
        rtc_sclk = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    function automatic logic [7:0] pick(input int sel);
        case (sel)
            0:       return time_sec;
            1:       return time_min;
            default: return time_hour;
        endcase
    endfunction

    task automatic wait_tick_from_commit(input int offset);
        int guard;
        guard = 0;
        while (cyc < wr_cyc + offset && guard < 4 * TICK_DIV) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 4 * TICK_DIV) begin
            n_bad++;
            $display("FAIL tick_wait: timed out after %0d cycles", guard);
        end
    endtask

    initial begin
        int         base;
        logic [7:0] exp_rd;
        logic [7:0] cmd_rd;

        vecs[0]  = '{8'h84, 8'h12, 0, 3'd0, 2, 8'h00};
        vecs[1]  = '{8'h8E, 8'h00, 1, 3'd7, 3, 8'h00};
        vecs[2]  = '{8'h84, 8'h23, 1, 3'd2, 2, 8'h23};
        vecs[3]  = '{8'h82, 8'h59, 1, 3'd1, 1, 8'h59};
        vecs[4]  = '{8'hC0, 8'h55, 0, 3'd0, 0, 8'h80};
        vecs[5]  = '{8'h00, 8'h55, 0, 3'd0, 0, 8'h80};
        vecs[6]  = '{8'h9E, 8'h11, 0, 3'd0, 0, 8'h80};
        vecs[7]  = '{8'h8C, 8'h33, 1, 3'd6, 3, 8'h00};
        vecs[8]  = '{8'h8E, 8'h80, 1, 3'd7, 3, 8'h00};
        vecs[9]  = '{8'h82, 8'h00, 0, 3'd0, 1, 8'h59};
        vecs[10] = '{8'h8E, 8'h00, 1, 3'd7, 3, 8'h00};

        repeat (3) @(negedge clk);
        chk("rst_sec", 32'(time_sec), 32'h80);
        chk("rst_min", 32'(time_min), 32'h00);
        chk("rst_hour", 32'(time_hour), 32'h00);
        chk("rst_oe", 32'(rtc_io_oe), 32'h0);
        chk("rst_out", 32'(rtc_io_out), 32'h0);
        chk("rst_wr", 32'(reg_wr), 32'h0);
        chk("rst_wr_addr", 32'(reg_wr_addr), 32'h0);
        rst = 1'b0;
        repeat (2 * H) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            base = wr_cnt;
            wr_xfer(vecs[i].cmd, vecs[i].data);
            chk($sformatf("vec%0d_wr_count", i), 32'(wr_cnt - base), 32'(vecs[i].exp_wr));
            if (vecs[i].exp_wr != 0)
                chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr_last), 32'(vecs[i].exp_addr));
            if (vecs[i].sel < 3)
                chk($sformatf("vec%0d_value", i), 32'(pick(vecs[i].sel)), 32'(vecs[i].exp_val));
            $display("vec %0d cmd %h data %h writes %0d sec %h min %h hour %h",
                     i, vecs[i].cmd, vecs[i].data, wr_cnt - base, time_sec, time_min, time_hour);
        end

        // 23:59:59 with CH=0 rolls to 00:00:00 after one tick period.
        base = wr_cnt;
        wr_xfer(8'h80, 8'h59);
        chk("roll_wr_count", 32'(wr_cnt - base), 32'd1);
        chk("roll_wr_addr", 32'(wr_addr_last), 32'd0);
        wait_tick_from_commit(TICK_DIV - 1);
        chk("roll_sec_before", 32'(time_sec), 32'h59);
        @(negedge clk);
        chk("roll_sec", 32'(time_sec), 32'h00);
        chk("roll_min", 32'(time_min), 32'h00);
        chk("roll_hour", 32'(time_hour), 32'h00);
        $display("rollover sec %h min %h hour %h", time_sec, time_min, time_hour);

        // Writing seconds restarts the tick counter.
        base = wr_cnt;
        wr_xfer(8'h80, 8'h00);
        chk("tick_wr_count", 32'(wr_cnt - base), 32'd1);
        chk("tick_wr_addr", 32'(wr_addr_last), 32'd0);
        wait_tick_from_commit(TICK_DIV - 1);
        chk("tick_sec_before", 32'(time_sec), 32'h00);
        @(negedge clk);
        chk("tick_sec_after", 32'(time_sec), 32'h01);
        $display("tick sec %h", time_sec);

        wr_xfer(8'h80, 8'h80);
        chk("halt_sec", 32'(time_sec), 32'h80);
        wr_xfer(8'h82, 8'h21);
        chk("set_min", 32'(time_min), 32'h21);
        wr_xfer(8'h84, 8'h12);
        chk("set_hour", 32'(time_hour), 32'h12);

        // Read minutes back over the serial line.
        base   = wr_cnt;
        exp_rd = 8'h21;
        cmd_rd = 8'h83;
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(cmd_rd[i]);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) sclk_pulse();
            chk($sformatf("rd_oe_bit%0d", i), 32'(rtc_io_oe), 32'h1);
            chk($sformatf("rd_data_bit%0d", i), 32'(rtc_io_out), 32'(exp_rd[i]));
        end
        sclk_pulse();
        chk("rd_oe_after", 32'(rtc_io_oe), 32'h0);
        frame_end();
        chk("rd_no_write", 32'(wr_cnt - base), 32'd0);
        $display("read cmd 83 done");

        // CE dropped after four data bits: the partial write is discarded.
        base = wr_cnt;
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(vecs[3].cmd[i]);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        frame_end();
        chk("abort_wr_count", 32'(wr_cnt - base), 32'd0);
        chk("abort_min", 32'(time_min), 32'h21);
        $display("aborted write min %h", time_min);

        // Reset in the middle of a read.
        frame_start();
        for (int i = 0; i < 8; i++) send_bit(cmd_rd[i]);
        chk("mid_rd_oe", 32'(rtc_io_oe), 32'h1);
        rst = 1'b1;
        #1;
        chk("rstmid_oe", 32'(rtc_io_oe), 32'h0);
        chk("rstmid_out", 32'(rtc_io_out), 32'h0);
        chk("rstmid_sec", 32'(time_sec), 32'h80);
        chk("rstmid_min", 32'(time_min), 32'h00);
        chk("rstmid_hour", 32'(time_hour), 32'h00);
        chk("rstmid_wr", 32'(reg_wr), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = wr_cnt;
        cmd_rd = 8'h8E;
        for (int i = 0; i < 8; i++) send_bit(cmd_rd[i]);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0);
            chk($sformatf("resume_oe%0d", i), 32'(rtc_io_oe), 32'h0);
        end
        frame_end();
        chk("resume_no_write", 32'(wr_cnt - base), 32'd0);
        $display("reset mid-read sec %h min %h hour %h", time_sec, time_min, time_hour);

        base = wr_cnt;
        wr_xfer(8'h84, 8'h12);
        chk("post_rst_wp_count", 32'(wr_cnt - base), 32'd0);
        chk("post_rst_wp_hour", 32'(time_hour), 32'h00);
        base = wr_cnt;
        wr_xfer(8'h8E, 8'h00);
        chk("post_rst_ctl_count", 32'(wr_cnt - base), 32'd1);
        chk("post_rst_ctl_addr", 32'(wr_addr_last), 32'd7);
        base = wr_cnt;
        wr_xfer(8'h82, 8'h05);
        chk("post_rst_min_count", 32'(wr_cnt - base), 32'd1);
        chk("post_rst_min_addr", 32'(wr_addr_last), 32'd1);
        chk("post_rst_min", 32'(time_min), 32'h05);
        $display("post-reset writes min %h", time_min);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
